// File: rtl/i2s_tdm_rcv.sv
// I2S / left-justified / TDM serial audio receiver: brings BCLK, LRCLK and din into xclk,
// deframes CHANNELS slots per frame and reports slot words, frame words, errors and lock.
module i2s_tdm_rcv #(
    parameter  int SLOT_BITS   = 16,
    parameter  int CHANNELS    = 2,
    parameter  int MODE        = 0,
    parameter  int DSTRB       = 0,
    parameter  int LOCK_FRAMES = 4,
    parameter  int TIMEOUT     = 1023,
    localparam int FB          = CHANNELS * SLOT_BITS,
    localparam int CW          = $clog2(CHANNELS)
) (
    input  logic                 xclk,
    input  logic                 xrst,
    input  logic                 BCLK,
    input  logic                 LRCLK,
    input  logic                 din,
    output logic [FB-1:0]        xData,
    output logic                 xData_rdy,
    output logic [SLOT_BITS-1:0] slot_data,
    output logic [CW-1:0]        slot_num,
    output logic                 slot_rdy,
    output logic                 frame_err,
    output logic                 locked,
    output logic                 xBrise,
    output logic                 xLRfall
);
    localparam int SW = $clog2(SLOT_BITS);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [2:0]           bclk_s_q, lr_s_q, din_s_q;
    logic [7:0]           bclk_pos_q;
    logic                 samp_pend_q;
    logic [IW-1:0]        idle_cnt_q;
    logic                 xBrise_q, xLRfall_q;

    state_t               state_q;
    logic                 skip_q;
    logic [SW-1:0]        slot_bit_q;
    logic [CW-1:0]        slot_idx_q;
    logic [FB-1:0]        shadow_q, xData_q;
    logic [SLOT_BITS-1:0] slot_data_q;
    logic [CW-1:0]        slot_num_q;
    logic                 xData_rdy_q, slot_rdy_q, frame_err_q, locked_q;
    logic [7:0]           lock_cnt_q;

    logic brise_w, lrfall_w, din_w, sample_w, timeout_w, last_bit_w, last_slot_w;

    // Edges are taken between stages 2 and 3; din stage 3 therefore lines up with the edge.
    assign brise_w     = bclk_s_q[1] & ~bclk_s_q[2];
    assign lrfall_w    = ~lr_s_q[1] & lr_s_q[2];
    assign din_w       = din_s_q[2];
    assign sample_w    = samp_pend_q && (bclk_pos_q == 8'(DSTRB));
    assign timeout_w   = !brise_w && (idle_cnt_q == IW'(TIMEOUT - 1));
    assign last_bit_w  = (slot_bit_q == SW'(SLOT_BITS - 1));
    assign last_slot_w = (slot_idx_q == CW'(CHANNELS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge xclk) begin
        if (xrst) begin
            bclk_s_q    <= '0;
            lr_s_q      <= '0;
            din_s_q     <= '0;
            bclk_pos_q  <= '0;
            samp_pend_q <= 1'b0;
            idle_cnt_q  <= '0;
            xBrise_q    <= 1'b0;
            xLRfall_q   <= 1'b0;
        end else begin
            bclk_s_q  <= {bclk_s_q[1:0], BCLK};
            lr_s_q    <= {lr_s_q[1:0], LRCLK};
            din_s_q   <= {din_s_q[1:0], din};
            xBrise_q  <= brise_w;
            xLRfall_q <= lrfall_w;
            if (brise_w)                bclk_pos_q <= '0;
            else if (bclk_pos_q != '1)  bclk_pos_q <= bclk_pos_q + 8'd1;
            // The pending flag keeps a cleared counter after reset from looking like a strobe.
            if (brise_w)                samp_pend_q <= 1'b1;
            else if (sample_w)          samp_pend_q <= 1'b0;
            if (brise_w)                idle_cnt_q <= '0;
            else if (idle_cnt_q != IW'(TIMEOUT)) idle_cnt_q <= idle_cnt_q + IW'(1);
        end
    end

    // NOTE: the shift and output registers are small and feed outputs, so they are reset too.
    always_ff @(posedge xclk) begin
        if (xrst) begin
            state_q     <= IDLE;
            skip_q      <= 1'b0;
            slot_bit_q  <= '0;
            slot_idx_q  <= '0;
            shadow_q    <= '0;
            xData_q     <= '0;
            slot_data_q <= '0;
            slot_num_q  <= '0;
            xData_rdy_q <= 1'b0;
            slot_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            xData_rdy_q <= 1'b0;
            slot_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (timeout_w) begin
                state_q    <= IDLE;
                lock_cnt_q <= '0;
                locked_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (lrfall_w) begin
                            state_q    <= RUN;
                            skip_q     <= (MODE == 0);
                            slot_bit_q <= '0;
                            slot_idx_q <= '0;
                        end
                    end
                    RUN: begin
                        if (lrfall_w) begin
                            // Frame edge before the last bit: short frame, restart at bit 0.
                            frame_err_q <= 1'b1;
                            lock_cnt_q  <= '0;
                            locked_q    <= 1'b0;
                            skip_q      <= (MODE == 0);
                            slot_bit_q  <= '0;
                            slot_idx_q  <= '0;
                        end else if (sample_w) begin
                            if (skip_q) begin
                                skip_q <= 1'b0;
                            end else begin
                                shadow_q <= {shadow_q[FB-2:0], din_w};
                                if (last_bit_w) begin
                                    slot_data_q <= {shadow_q[SLOT_BITS-2:0], din_w};
                                    slot_num_q  <= slot_idx_q;
                                    slot_rdy_q  <= 1'b1;
                                    slot_bit_q  <= '0;
                                    slot_idx_q  <= slot_idx_q + 1'b1;
                                    if (last_slot_w) begin
                                        xData_q     <= {shadow_q[FB-2:0], din_w};
                                        xData_rdy_q <= 1'b1;
                                        state_q     <= DONE;
                                        if (lock_cnt_q < 8'(LOCK_FRAMES))
                                            lock_cnt_q <= lock_cnt_q + 8'd1;
                                        locked_q <= (lock_cnt_q + 8'd1 >= 8'(LOCK_FRAMES));
                                    end
                                end else begin
                                    slot_bit_q <= slot_bit_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign xData     = xData_q;
    assign xData_rdy = xData_rdy_q;
    assign slot_data = slot_data_q;
    assign slot_num  = slot_num_q;
    assign slot_rdy  = slot_rdy_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;
    assign xBrise    = xBrise_q;
    assign xLRfall   = xLRfall_q;
endmodule

// File: doc/i2s_tdm_rcv.md
# i2s_tdm_rcv

Parametrised I2S / left-justified / TDM serial audio receiver. It brings the external BCLK, LRCLK and din pins into the xclk domain and deframes 2 to 16 channels per frame. It presents both a per-slot stream and a whole-frame word, and adds frame-error detection, a BCLK-loss timeout and a lock indicator. It sits between an external codec/ADC serial port and the xclk-domain DSP and transport logic.

## Interface
- SLOT_BITS, 16: BCLK periods (data bits) per channel slot; 8..32.
- CHANNELS, 2: slots per frame; even, 2..16.
- MODE, 0: 0 = I2S (MSB one BCLK after the frame edge); 1 = left-justified (MSB on the first BCLK after the frame edge).
- DSTRB, 0: xclk cycles after a synchronised BCLK rise at which din is sampled; must be less than xclk cycles per BCLK.
- LOCK_FRAMES, 4: consecutive good frames needed to assert locked; 1..255.
- TIMEOUT, 1023: xclk cycles without a BCLK rise before loss is declared.
- Derived: FB = CHANNELS*SLOT_BITS; CW = clog2(CHANNELS).
- xclk, in, 1: system clock; all logic is on its rising edge.
- xrst, in, 1: synchronous, active-high reset.
- BCLK, in, 1: bit clock, asynchronous to xclk.
- LRCLK, in, 1: frame clock, asynchronous; its falling edge is the frame start.
- din, in, 1: serial data, synchronous to BCLK.
- xData, out, FB: last complete frame; slot 0 occupies the MSBs.
- xData_rdy, out, 1: one-xclk pulse when xData updates.
- slot_data, out, SLOT_BITS: most recently completed slot.
- slot_num, out, CW: index of slot_data.
- slot_rdy, out, 1: one-xclk pulse when slot_data updates.
- frame_err, out, 1: one-xclk pulse on a short frame.
- locked, out, 1: high while framing is stable.
- xBrise, out, 1: one-xclk pulse on a synchronised BCLK rise.
- xLRfall, out, 1: one-xclk pulse on a synchronised LRCLK fall.

## Operation
- Synchronisation:
  - BCLK, LRCLK and din each pass through three flops, so all three see equal delay.
  - Edges are detected between stages 2 and 3.
  - bclk_pos counter: cleared on xBrise, otherwise increments, saturating at all-ones. din (stage 3) is sampled when bclk_pos == DSTRB.
- States:
  - IDLE (after reset): wait for xLRfall, then go to RUN with bit_cnt = 0.
  - RUN: bit_cnt counts xBrise events since the frame edge.
    - Data bit index d = bit_cnt−1 in MODE 0; d = bit_cnt in MODE 1.
    - Sampled bits with d < 0 are discarded. Valid bits shift MSB-first into the slot shift register and into a frame shadow register.
    - When d reaches a multiple of SLOT_BITS minus 1 and that bit is sampled: the next xclk loads slot_data and slot_num and pulses slot_rdy.
    - When d = FB−1 is sampled: the next xclk loads the shadow into xData, pulses xData_rdy and enters DONE.
  - DONE: further BCLK rises (padding) are ignored. xLRfall returns to RUN with bit_cnt = 0.
- Short frame: xLRfall in RUN with d < FB−1.
  - Pulse frame_err, discard partial shadow data (xData is unchanged), clear the lock counter.
  - Restart RUN at bit 0.
- Simultaneous events: an xLRfall in the same cycle as the final sample counts as a short frame; the restart takes priority.
- LRCLK rising edge: ignored for alignment, so channel pairing is purely positional.
- Lock:
  - lock_cnt increments on each xData_rdy and saturates at LOCK_FRAMES; locked = (lock_cnt == LOCK_FRAMES).
  - Cleared by frame_err or by timeout.
- Timeout: idle counter reset by xBrise. When it reaches TIMEOUT it clears lock_cnt and forces IDLE. Once there, it saturates and does not re-fire.
- Reset:
  - All outputs go to 0: xData, slot_data, slot_num, pulses, locked.
  - Synchroniser flops, counters and state clear; state = IDLE.
  - A reset mid-frame discards that frame. The next frame is received only after a fresh xLRfall.

## Timing
- Pin to edge pulse: an LRCLK/BCLK transition shows on xLRfall/xBrise 2–3 xclk later (synchroniser uncertainty).
- Last-bit sample to xData_rdy/slot_rdy: 1 xclk.
- xData, slot_data and slot_num are held until the next respective ready pulse. There is no back-pressure, so the consumer must accept within one slot time.
- Minimum xclk/BCLK ratio: 4.

## Test plan
- CHANNELS=2, SLOT_BITS=16, MODE=0, xclk = 8×BCLK, left 0xA5C3, right 0x1234:
  - xData = 0xA5C31234 with one xData_rdy pulse per frame.
  - slot_rdy pulses twice: slot_num 0 (0xA5C3), then 1 (0x1234).
- Same stream with MODE=1 and no delay bit → identical xData; a MODE=0 receiver on this stream gets the value shifted by one bit.
- CHANNELS=8, SLOT_BITS=32, slot k = 0x01010101*k, 4 frames:
  - 8 slot_rdy pulses per frame with slot_num 0..7.
  - locked rises on the xData_rdy of frame 4 (LOCK_FRAMES=4).
- Frame truncated by an early LRCLK fall at bit 20 of 32:
  - frame_err pulses once, xData is unchanged, locked drops.
  - The following full frame is received correctly.
- BCLK stopped for TIMEOUT+10 xclk while locked:
  - locked goes to 0 at TIMEOUT and state returns to IDLE.
  - After BCLK resumes, no data is output until an xLRfall.
- xrst asserted mid-frame for 1 xclk:
  - All outputs are 0 the next cycle.
  - The first xData_rdy comes after the next complete frame.
